sram_2p_scrub_ext: RTL and testbench
====================================

Name: sram_2p_scrub_ext

Overview:
- Parametrised one-clock simple-dual-port RAM model: one write port (W0), one read port (R0).
- Generalises the fixed-size cache/scratchpad memory macros in width, depth, mask granularity and read latency.
- Adds read-during-write forwarding, a read-valid strobe and a hardware clear (scrub) engine that initialises every word after reset or on request.
- Used by the SoC for tag, data and scratch arrays where deterministic post-reset contents are required.

Parameters:
- ADDR_W, 10, address width; depth = 2^ADDR_W words.
- DATA_W, 32, word width in bits.
- MASK_GRAN, 8, bits per write-mask lane; DATA_W must be a multiple; MASK_W = DATA_W/MASK_GRAN.
- READ_LAT, 1, read latency in cycles; legal values 1 or 2.
- BYPASS, 1, 1 = same-address read-during-write returns new data; 0 = returns old data.
- INIT_VALUE, 0, DATA_W-bit value written to every word by the scrub engine.

Ports:
- clock  in  1  single clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- W0_en  in  1  write enable.
- W0_addr  in  ADDR_W  write address.
- W0_data  in  DATA_W  write data.
- W0_mask  in  MASK_W  per-lane write enable; lane i covers bits [i*MASK_GRAN +: MASK_GRAN].
- R0_en  in  1  read enable.
- R0_addr  in  ADDR_W  read address.
- R0_data  out  DATA_W  read data, registered, holds the last value.
- R0_valid  out  1  one-cycle strobe aligned with new R0_data.
- init_start  in  1  request a full re-scrub.
- init_busy  out  1  scrub in progress; ports ignored while high.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are named clock and reset_n.
- Reset values:
  - FSM enters CLEAR; counter = 0; init_busy = 1.
  - R0_valid = 0; R0_data = 0; read pipeline valid bits = 0.
  - The RAM array itself is not reset.
- FSM states:
  - CLEAR: each cycle writes INIT_VALUE to ram[counter], full word, then increments the counter. On the cycle counter = 2^ADDR_W-1 the write completes and the FSM moves to IDLE. Total 2^ADDR_W cycles; init_busy drops on the first IDLE cycle.
  - IDLE: if init_start=1, the counter is cleared and the FSM moves to CLEAR on the next edge. The W0/R0 access presented in that same cycle is still performed.
  - init_start during CLEAR is ignored and does not restart the count.
  - reset_n asserted mid-CLEAR restarts the scrub from address 0 after release.
- In CLEAR, W0_en and R0_en are ignored: no user writes, R0_valid stays 0, R0_data holds.
- Write (IDLE, W0_en=1): lanes with W0_mask[i]=1 are updated at the edge; other lanes are unchanged. W0_mask=0 is a no-op.
- Read (IDLE, R0_en=1):
  - READ_LAT=1: R0_data and R0_valid=1 update at the next edge.
  - READ_LAT=2: one extra register stage; data and valid appear two edges after the request.
  - Back-to-back reads are fully pipelined, one per cycle.
- R0_data holds its last value until the next valid read completes. R0_valid is high for exactly one cycle per accepted read.
- Read-during-write to the same address in the same cycle:
  - BYPASS=1: returned word = written lanes from W0_data, unwritten lanes from the old contents.
  - BYPASS=0: returned word = old contents.
  - Different addresses: no interaction.
- With READ_LAT=2, a write to the read address in the cycle after the read is not forwarded; the result reflects the array at the read edge.
- Address wrap: the counter is ADDR_W+1 bits internally, compared to the last address; no wrap past the top.
- Illegal parameters (DATA_W % MASK_GRAN != 0, READ_LAT not in {1,2}) are caught by an elaboration-time check.

Decomposition:
- Shared package: FSM state enum {ST_IDLE, ST_CLEAR}, READ_LAT legal range constants, mask-expansion function (MASK_W mask to DATA_W bit-enable).
- One sub-module, sram_rd_pipe: the read-data/valid register chain (depth READ_LAT) with hold-when-idle behaviour. The array, write/bypass merge and FSM stay in the top.

Test Plan:
- Release reset_n, idle ports -> init_busy=1 for exactly 1024 cycles then 0; reads of addr 0, 0x155, 0x3FF return 0x00000000 with R0_valid one cycle after R0_en.
- Write 0xDEADBEEF to addr 5 with mask 4'b0101, then read addr 5 -> R0_data=0x00AD00EF (after clear to 0).
- Same-cycle write 0x11223344 mask 4'b1111 and read of addr 7 (old 0xAAAAAAAA): BYPASS=1 -> 0x11223344; BYPASS=0 -> 0xAAAAAAAA; with mask 4'b0011 and BYPASS=1 -> 0xAAAA3344.
- READ_LAT=2, reads of addrs 1,2,3 on consecutive cycles -> data on cycles +2,+3,+4, R0_valid high for 3 consecutive cycles; R0_data holds addr-3 data afterwards.
- Pulse init_start in IDLE, then assert reset_n low at scrub counter 300 -> after release init_busy lasts a full 1024 cycles; init_start pulsed mid-CLEAR does not extend it; all words read back INIT_VALUE.
- During CLEAR drive W0_en=1 addr 9 data 0xFFFFFFFF and R0_en=1 -> no R0_valid; after clear, addr 9 reads INIT_VALUE.

Source files
------------

// File: rtl/sram_2p_scrub_ext_pkg.sv
// Shared types and helpers for the scrubbed simple-dual-port RAM model.
package sram_2p_scrub_ext_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;

  // Upper bounds for the mask-expansion helper; callers slice the result.
  localparam int MAX_DATA_W = 1024;
  localparam int MAX_MASK_W = 1024;

  function automatic logic [MAX_DATA_W-1:0] expand_mask(
    input logic [MAX_MASK_W-1:0] mask,
    input int                    gran,
    input int                    data_w
  );
    logic [MAX_DATA_W-1:0] ben;
    ben = {MAX_DATA_W{1'b0}};
    for (int b = 0; b < MAX_DATA_W; b++) begin
      if (b < data_w) begin
        ben[b] = mask[b / gran];
      end else begin
        ben[b] = 1'b0;
      end
    end
    return ben;
  endfunction

endpackage

// File: rtl/sram_2p_scrub_ext_rd_pipe.sv
// Read-data/valid register chain of depth READ_LAT; data holds when no read completes.
module sram_rd_pipe
  import sram_2p_scrub_ext_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data
);

  logic [READ_LAT-1:0] v_r;
  logic [DATA_W-1:0]   d_r [READ_LAT];

  // Shift valid every cycle; data only moves alongside a valid so the tail holds.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v_r <= {READ_LAT{1'b0}};
      for (int i = 0; i < READ_LAT; i++) begin
        d_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      v_r[0] <= rd_valid;
      if (rd_valid) begin
        d_r[0] <= rd_data;
      end
      for (int i = 1; i < READ_LAT; i++) begin
        v_r[i] <= v_r[i-1];
        if (v_r[i-1]) begin
          d_r[i] <= d_r[i-1];
        end
      end
    end
  end

  assign q_valid = v_r[READ_LAT-1];
  assign q_data  = d_r[READ_LAT-1];

endmodule

// File: rtl/sram_2p_scrub_ext.sv
// Parametrised simple-dual-port RAM with masked writes, read-during-write
// forwarding and a clear engine that scrubs every word after reset or on request.
module sram_2p_scrub_ext
  import sram_2p_scrub_ext_pkg::*;
#(
  parameter int                       ADDR_W     = 10,
  parameter int                       DATA_W     = 32,
  parameter int                       MASK_GRAN  = 8,
  parameter int                       READ_LAT   = 1,
  parameter int                       BYPASS     = 1,
  parameter logic [DATA_W-1:0]        INIT_VALUE = {DATA_W{1'b0}}
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          W0_en,
  input  logic [ADDR_W-1:0]             W0_addr,
  input  logic [DATA_W-1:0]             W0_data,
  input  logic [DATA_W/MASK_GRAN-1:0]   W0_mask,
  input  logic                          R0_en,
  input  logic [ADDR_W-1:0]             R0_addr,
  output logic [DATA_W-1:0]             R0_data,
  output logic                          R0_valid,
  input  logic                          init_start,
  output logic                          init_busy
);

  localparam int                MASK_W    = DATA_W / MASK_GRAN;
  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

  if (((DATA_W % MASK_GRAN) != 0) || (READ_LAT < READ_LAT_MIN) || (READ_LAT > READ_LAT_MAX))
  begin : g_bad_param
    $error("sram_2p_scrub_ext: DATA_W must be a multiple of MASK_GRAN and READ_LAT must be 1 or 2");
  end

  state_e              state_r, state_nxt_s;
  logic [ADDR_W:0]     cnt_r, cnt_nxt_s;
  logic                busy_r;
  logic                clear_s, idle_s;
  logic                wr_fire_s, rd_fire_s, same_addr_s;
  logic [MAX_DATA_W-1:0] ben_full_s;
  logic [DATA_W-1:0]   ben_s, old_w_s, wr_word_s, rd_word_s;
  logic [DATA_W-1:0]   ram_r [DEPTH];

  assign clear_s     = (state_r == ST_CLEAR);
  assign idle_s      = (state_r == ST_IDLE);
  assign wr_fire_s   = idle_s & W0_en;
  assign rd_fire_s   = idle_s & R0_en;
  assign same_addr_s = wr_fire_s & (W0_addr == R0_addr);

  // Scrub sequencing: CLEAR walks the counter to the last word, IDLE waits for init_start.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_CLEAR: begin
        if (cnt_r == LAST_ADDR) begin
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r + {{ADDR_W{1'b0}}, 1'b1};
        end
      end
      ST_IDLE: begin
        if (init_start) begin
          state_nxt_s = ST_CLEAR;
          cnt_nxt_s   = {(ADDR_W+1){1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_CLEAR;
        cnt_nxt_s   = {(ADDR_W+1){1'b0}};
      end
    endcase
  end

  // FSM state, scrub counter and the registered busy flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_CLEAR;
      cnt_r   <= {(ADDR_W+1){1'b0}};
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= (state_nxt_s == ST_CLEAR);
    end
  end

  assign init_busy = busy_r;

  // Lane merge doubles as the forwarded word when read and write addresses match.
  always_comb begin
    ben_full_s = expand_mask({{(MAX_MASK_W-MASK_W){1'b0}}, W0_mask}, MASK_GRAN, DATA_W);
    ben_s      = ben_full_s[DATA_W-1:0];
    old_w_s    = ram_r[W0_addr];
    wr_word_s  = (old_w_s & ~ben_s) | (W0_data & ben_s);
    if ((BYPASS != 0) && same_addr_s) begin
      rd_word_s = wr_word_s;
    end else begin
      rd_word_s = ram_r[R0_addr];
    end
  end

  // Storage array; intentionally not reset, the scrub engine provides known contents.
  always_ff @(posedge clock) begin
    if (clear_s) begin
      ram_r[cnt_r[ADDR_W-1:0]] <= INIT_VALUE;
    end else if (wr_fire_s) begin
      ram_r[W0_addr] <= wr_word_s;
    end
  end

  sram_rd_pipe #(
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_rd_pipe (
    .clock    (clock),
    .reset_n  (reset_n),
    .rd_valid (rd_fire_s),
    .rd_data  (rd_word_s),
    .q_valid  (R0_valid),
    .q_data   (R0_data)
  );

endmodule

// File: tb/tb_sram_2p_scrub_ext.sv
// Scoreboard bench: two instances (READ_LAT=1/BYPASS=1 and READ_LAT=2/BYPASS=0) share stimulus.
module tb_sram_2p_scrub_ext;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        W0_en, R0_en, init_start;
  logic [9:0]  W0_addr, R0_addr;
  logic [31:0] W0_data;
  logic [3:0]  W0_mask;
  logic [31:0] a_data, b_data;
  logic        a_valid, b_valid, a_busy, b_busy;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  sram_2p_scrub_ext #(
    .ADDR_W(10), .DATA_W(32), .MASK_GRAN(8), .READ_LAT(1), .BYPASS(1), .INIT_VALUE(32'h0000_0000)
  ) dut_a (
    .clock(clock), .reset_n(reset_n),
    .W0_en(W0_en), .W0_addr(W0_addr), .W0_data(W0_data), .W0_mask(W0_mask),
    .R0_en(R0_en), .R0_addr(R0_addr), .R0_data(a_data), .R0_valid(a_valid),
    .init_start(init_start), .init_busy(a_busy)
  );

  sram_2p_scrub_ext #(
    .ADDR_W(10), .DATA_W(32), .MASK_GRAN(8), .READ_LAT(2), .BYPASS(0), .INIT_VALUE(32'h0000_0000)
  ) dut_b (
    .clock(clock), .reset_n(reset_n),
    .W0_en(W0_en), .W0_addr(W0_addr), .W0_data(W0_data), .W0_mask(W0_mask),
    .R0_en(R0_en), .R0_addr(R0_addr), .R0_data(b_data), .R0_valid(b_valid),
    .init_start(init_start), .init_busy(b_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare whenever a DUT presents R0_valid.
  always @(negedge clock) begin
    exp_t e;
    if (a_valid === 1'b1) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = qa.pop_front();
        chk("a_data", a_data, e.data);
        chk("a_cycle", cyc, e.cyc);
      end
    end else if (qa.size() > 0 && qa[0].cyc <= cyc) begin
      e = qa.pop_front();
      chk("a_missing_valid", 32'd0, 32'd1);
    end
    if (b_valid === 1'b1) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = qb.pop_front();
        chk("b_data", b_data, e.data);
        chk("b_cycle", cyc, e.cyc);
      end
    end else if (qb.size() > 0 && qb[0].cyc <= cyc) begin
      e = qb.pop_front();
      chk("b_missing_valid", 32'd0, 32'd1);
    end
  end

  task automatic op(input logic we, input logic [9:0] wa, input logic [31:0] wd, input logic [3:0] wm,
                    input logic re, input logic [9:0] ra, input logic [31:0] ea, input logic [31:0] eb,
                    input logic st);
    exp_t e;
    @(negedge clock);
    W0_en = we; W0_addr = wa; W0_data = wd; W0_mask = wm;
    R0_en = re; R0_addr = ra; init_start = st;
    if (re) begin
      e.data = ea; e.cyc = cyc + 1; qa.push_back(e);
      e.data = eb; e.cyc = cyc + 2; qb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      W0_en = 1'b0; R0_en = 1'b0; init_start = 1'b0;
    end
  endtask

  task automatic junk();
    W0_en = 1'b1; W0_addr = 10'd9; W0_data = 32'hFFFF_FFFF; W0_mask = 4'hF;
    R0_en = 1'b1; R0_addr = 10'd9;
  endtask

  // Counts edges from a busy start until init_busy drops, with CLEAR-time port noise.
  task automatic measure_clear(input int pulse_at);
    int n;
    n = 0;
    while (a_busy === 1'b1 && n < 3000) begin
      @(posedge clock);
      n++;
      #1;
      init_start = (n == pulse_at);
      junk();
    end
    W0_en = 1'b0; R0_en = 1'b0; init_start = 1'b0;
    chk("clear_len", n, 32'd1024);
    chk("b_busy_after_clear", {31'd0, b_busy}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    W0_en = 1'b0; R0_en = 1'b0; init_start = 1'b0;
    W0_addr = 10'd0; R0_addr = 10'd0; W0_data = 32'd0; W0_mask = 4'd0;
    repeat (3) @(negedge clock);
    chk("rst_a_busy", {31'd0, a_busy}, 32'd1);
    chk("rst_b_busy", {31'd0, b_busy}, 32'd1);
    chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
    chk("rst_a_data", a_data, 32'd0);
    chk("rst_b_data", b_data, 32'd0);
    reset_n = 1'b1;
    measure_clear(-1);

    op(1'b0, 10'd0, 32'd0, 4'h0, 1'b1, 10'h000, 32'h0, 32'h0, 1'b0);
    op(1'b0, 10'd0, 32'd0, 4'h0, 1'b1, 10'h155, 32'h0, 32'h0, 1'b0);
    op(1'b0, 10'd0, 32'd0, 4'h0, 1'b1, 10'h3FF, 32'h0, 32'h0, 1'b0);
    op(1'b0, 10'd0, 32'd0, 4'h0, 1'b1, 10'd9,   32'h0, 32'h0, 1'b0);
    idle(1);
    // Partial mask, then a zero-mask no-op write.
    op(1'b1, 10'd5, 32'hDEAD_BEEF, 4'b0101, 1'b0, 10'd0, 32'h0, 32'h0, 1'b0);
    op(1'b1, 10'd5, 32'hFFFF_FFFF, 4'b0000, 1'b0, 10'd0, 32'h0, 32'h0, 1'b0);
    op(1'b0, 10'd0, 32'd0, 4'h0, 1'b1, 10'd5, 32'h00AD_00EF, 32'h00AD_00EF, 1'b0);
    // Same-address read-during-write.
    op(1'b1, 10'd7, 32'hAAAA_AAAA, 4'hF, 1'b0, 10'd0, 32'h0, 32'h0, 1'b0);
    op(1'b1, 10'd7, 32'h1122_3344, 4'hF, 1'b1, 10'd7, 32'h1122_3344, 32'hAAAA_AAAA, 1'b0);
    op(1'b1, 10'd7, 32'hAAAA_AAAA, 4'hF, 1'b0, 10'd0, 32'h0, 32'h0, 1'b0);
    op(1'b1, 10'd7, 32'h1122_3344, 4'b0011, 1'b1, 10'd7, 32'hAAAA_3344, 32'hAAAA_AAAA, 1'b0);
    op(1'b0, 10'd0, 32'd0, 4'h0, 1'b1, 10'd7, 32'hAAAA_3344, 32'hAAAA_3344, 1'b0);
    // Back-to-back pipelined reads.
    op(1'b1, 10'd1, 32'h0101_0101, 4'hF, 1'b0, 10'd0, 32'h0, 32'h0, 1'b0);
    op(1'b1, 10'd2, 32'h0202_0202, 4'hF, 1'b0, 10'd0, 32'h0, 32'h0, 1'b0);
    op(1'b1, 10'd3, 32'h0303_0303, 4'hF, 1'b0, 10'd0, 32'h0, 32'h0, 1'b0);
    op(1'b0, 10'd0, 32'd0, 4'h0, 1'b1, 10'd1, 32'h0101_0101, 32'h0101_0101, 1'b0);
    op(1'b0, 10'd0, 32'd0, 4'h0, 1'b1, 10'd2, 32'h0202_0202, 32'h0202_0202, 1'b0);
    op(1'b0, 10'd0, 32'd0, 4'h0, 1'b1, 10'd3, 32'h0303_0303, 32'h0303_0303, 1'b0);
    idle(4);
    chk("a_hold", a_data, 32'h0303_0303);
    chk("b_hold", b_data, 32'h0303_0303);
    // Write one cycle after a read is not forwarded; different addresses don't interact.
    op(1'b0, 10'd0, 32'd0, 4'h0, 1'b1, 10'd2, 32'h0202_0202, 32'h0202_0202, 1'b0);
    op(1'b1, 10'd2, 32'hFFFF_FFFF, 4'hF, 1'b0, 10'd0, 32'h0, 32'h0, 1'b0);
    op(1'b1, 10'd10, 32'h0000_0005, 4'hF, 1'b1, 10'd5, 32'h00AD_00EF, 32'h00AD_00EF, 1'b0);
    op(1'b0, 10'd0, 32'd0, 4'h0, 1'b1, 10'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    // init_start with a concurrent access that must still complete.
    op(1'b1, 10'd9, 32'h1234_5678, 4'hF, 1'b1, 10'd5, 32'h00AD_00EF, 32'h00AD_00EF, 1'b1);
    repeat (300) begin
      @(negedge clock);
      init_start = 1'b0;
      junk();
    end
    reset_n = 1'b0;
    idle(2);
    chk("mid_rst_a_busy", {31'd0, a_busy}, 32'd1);
    chk("mid_rst_b_valid", {31'd0, b_valid}, 32'd0);
    chk("mid_rst_b_data", b_data, 32'd0);
    reset_n = 1'b1;
    measure_clear(500);
    idle(1);
    for (int i = 0; i < 1024; i++) begin
      op(1'b0, 10'd0, 32'd0, 4'h0, 1'b1, 10'(i), 32'h0, 32'h0, 1'b0);
    end
    idle(1);
    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) begin
      @(negedge clock);
    end
    chk("qa_drained", qa.size(), 32'd0);
    chk("qb_drained", qb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
